// File: rtl/llm_pkg.sv
// Shared types and constants for the outlier split scheduler.
package llm_pkg;

   typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} split_state_t;

   // Magnitude at or above which an element marks its column as an outlier.
   localparam int OUTLIER_MAG = 128;

   // The detect rule is written for 16-bit two's complement elements.
   localparam int DET_W = 16;

endpackage

// File: rtl/outlier_lane_detect.sv
// Flags a single 16-bit signed element whose magnitude reaches OUTLIER_MAG.
module outlier_lane_detect
   import llm_pkg::*;
(
   input  logic [DET_W-1:0] x_i,
   output logic             flag_o
);

   localparam int MAG_BIT = $clog2(OUTLIER_MAG);

   logic [DET_W-2-MAG_BIT:0] upper;
   logic [MAG_BIT-1:0]       lower;

   assign upper = x_i[DET_W-2:MAG_BIT];
   assign lower = x_i[MAG_BIT-1:0];

   // Positive: any bit at or above 2^7 set. Negative: magnitude >= 128 unless the
   // upper bits are all ones with a nonzero low part (i.e. -1..-127).
   always_comb begin
      if (x_i[DET_W-1]) flag_o = !(&upper) || (lower == '0);
      else              flag_o = |upper;
   end

endmodule

// File: rtl/outlier_split_scheduler.sv
// Buffers one activation tile, finds outlier columns, then replays the tile as
// a hi stream (outlier columns) and lo stream (remaining columns), zero-masked.
module outlier_split_scheduler
   import llm_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int PARALLELISM = 4,
   parameter int ROWS        = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [PARALLELISM*DATA_WIDTH-1:0]   data_in,
   input  logic                                data_in_valid,
   output logic                                data_in_ready,
   output logic [PARALLELISM*DATA_WIDTH-1:0]   hi_out,
   output logic [PARALLELISM*DATA_WIDTH-1:0]   lo_out,
   output logic [PARALLELISM-1:0]              col_mask,
   output logic [$clog2(PARALLELISM+1)-1:0]    outlier_cnt,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic                                out_last
);

   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(PARALLELISM+1);
   localparam int BW = PARALLELISM*DATA_WIDTH;
   localparam logic [RW-1:0] LAST_ROW = RW'(ROWS-1);

   split_state_t             state_q, state_d;
   logic [RW-1:0]            row_q, rd_q;
   logic [PARALLELISM-1:0]   flags, mask_acc_q, mask_d, col_mask_q;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [BW-1:0]            buf_q [ROWS];
   logic                     in_fire, out_fire, fill_done, drain_done;

   for (genvar g = 0; g < PARALLELISM; g++) begin : g_det
      outlier_lane_detect u_det (
         .x_i    (data_in[g*DATA_WIDTH +: DET_W]),
         .flag_o (flags[g])
      );
   end

   assign in_fire    = data_in_valid && data_in_ready;
   assign out_fire   = out_valid && out_ready;
   assign fill_done  = in_fire && (row_q == LAST_ROW);
   assign drain_done = out_fire && (rd_q == LAST_ROW);
   assign mask_d     = mask_acc_q | flags;

   // Outlier count of the mask being committed at the end of FILL.
   always_comb begin
      cnt_d = '0;
      for (int i = 0; i < PARALLELISM; i++) cnt_d = cnt_d + CW'(mask_d[i]);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= FILL;
      else     state_q <= state_d;
   end

   // Next state: FILL until ROWS beats are in, DRAIN until ROWS beats are out.
   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL:    if (fill_done)  state_d = DRAIN;
         DRAIN:   if (drain_done) state_d = FILL;
         default: state_d = FILL;
      endcase
   end

   // Outputs: handshake flags plus the current buffer row split by col_mask.
   always_comb begin
      data_in_ready = (state_q == FILL) && !rst;
      out_valid     = (state_q == DRAIN);
      out_last      = out_valid && (rd_q == LAST_ROW);
      col_mask      = col_mask_q;
      outlier_cnt   = cnt_q;
      hi_out        = '0;
      lo_out        = '0;
      if (out_valid) begin
         for (int i = 0; i < PARALLELISM; i++) begin
            if (col_mask_q[i]) hi_out[i*DATA_WIDTH +: DATA_WIDTH] = buf_q[rd_q][i*DATA_WIDTH +: DATA_WIDTH];
            else               lo_out[i*DATA_WIDTH +: DATA_WIDTH] = buf_q[rd_q][i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Fill/drain pointers and mask accumulation; reset drops any partial tile.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_q      <= '0;
         rd_q       <= '0;
         mask_acc_q <= '0;
         col_mask_q <= '0;
         cnt_q      <= '0;
      end else begin
         if (in_fire) begin
            if (fill_done) begin
               row_q      <= '0;
               mask_acc_q <= '0;
               col_mask_q <= mask_d;
               cnt_q      <= cnt_d;
            end else begin
               row_q      <= row_q + 1'b1;
               mask_acc_q <= mask_d;
            end
         end
         if (out_fire) rd_q <= drain_done ? '0 : rd_q + 1'b1;
      end
   end

   // Tile storage; contents need no reset since rows are always rewritten before replay.
   always_ff @(posedge clk) begin
      if (in_fire) buf_q[row_q] <= data_in;
   end

endmodule
